case_7_mul_rr_sched: RTL and testbench
======================================

Name: case_7_mul_rr_sched

Overview:
- Round-robin scheduler that shares one pipelined signed multiplier (10-bit signed x 8-bit signed -> 16-bit) among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- Granted operations flow through a MUL_STAGES-deep pipeline. Each result returns with the requester ID on a single valid/ready result port.
- Sits between kernel loop bodies and the shared multiplier resource in the case_7 datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID (clog2(NUM_REQ), min 1).
- MUL_STAGES, 1, multiplier pipeline depth in cycles (1..4).

Ports:
- ap_clk  in  1  clock, all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*10  packed signed operand A; requester i at bits [10i+9:10i].
- req_b  in  NUM_REQ*8  packed signed operand B; requester i at bits [8i+7:8i].
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_data  out  16  signed product.
- res_id  out  ID_W  requester index of result.
- busy  out  1  any pipeline stage holds valid data.

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valids=0, res_valid=0, res_data=0, res_id=0, req_ready=0, busy=0, rr pointer=0.
- stall = res_valid & ~res_ready. While stall, all pipeline registers hold and req_ready=0.
- Arbitration is combinational each cycle.
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ. The first set bit wins.
  - req_ready[win] = ~stall; all other bits are 0.
  - req_ready does not depend on res_ready except through stall.
- Accept = req_valid[i] & req_ready[i]. On accept:
  - Stage 1 captures a, b and id with valid=1.
  - ptr <= (win+1) mod NUM_REQ.
  - ptr is unchanged if no accept.
- Without an accept and without stall, stage 1 valid <= 0 (bubble).
- Pipeline: stage k+1 <= stage k when ~stall. The last stage drives res_valid/res_data/res_id.
- Latency: accept at cycle T -> res_valid at T+MUL_STAGES, absent stalls. Throughput is 1 per cycle.
- Arithmetic:
  - Full 18-bit signed product, computed in stage 1.
  - Default res_data = product[15:0] (two's-complement wrap).
- Result handshake: a result is held stable until res_ready=1. A new result may appear in the same cycle as the prior one is accepted.
- busy = OR of all stage valids.
- Simultaneous: a requester deasserting req_valid in the cycle it was not granted loses nothing. req_valid held high with changing data while not granted is legal; the sampled data is that of the accept cycle.
- Reset mid-operation: in-flight operations are discarded; no result is emitted for them.
- NUM_REQ not a power of two: the pointer wraps from NUM_REQ-1 to 0. ID values >= NUM_REQ are never produced.

Optional Feature:
- CASE_7_MUL_RR_SCHED_SAT_EN defined:
  - res_data saturates the 18-bit product to [-32768, 32767].
  - Extra output sat_flag (1 bit, reset 0) is set alongside res_data when clamping occurred.
- Undefined: res_data wraps as product[15:0]; the sat_flag port is absent.

Test Plan:
- Single requester, MUL_STAGES=1:
  - req 2 issues a=100, b=-3 with res_ready=1 -> res_valid next cycle, res_data=-300 (0xFED4), res_id=2.
- All 4 requesters valid continuously, res_ready=1:
  - Grants follow 0,1,2,3,0,...
  - res_id sequence matches; one result per cycle after the initial latency.
- Back-pressure:
  - Hold res_ready=0 for 3 cycles with res_valid=1.
  - Required: res_data/res_id stable, req_ready all 0, no accepts.
  - Release -> results resume in order, none lost or duplicated.
- Overflow:
  - a=511, b=127 -> res_data=0xFD81 (wrap); with SAT_EN 32767, sat_flag=1.
  - a=-512, b=-128 -> 0x0000 wrap; with SAT_EN 32767, sat_flag=1.
- Reset mid-flight with MUL_STAGES=3:
  - Assert ap_rst_n=0 with 2 ops in flight.
  - Required: all outputs 0 immediately, ptr=0.
  - After release, no stale results appear; first grant goes to lowest valid index.
- NUM_REQ=3:
  - Only requesters 0 and 2 valid -> grants alternate 0,2,0,2.
  - ptr wraps correctly from 2 to 0.

Source files
------------

// File: rtl/case_7_mul_rr_sched.sv
// Round-robin scheduler sharing one pipelined signed multiplier (10b x 8b) among NUM_REQ
// requesters. Results return in grant order with the requester ID on a valid/ready port.
// Optional feature macro: CASE_7_MUL_RR_SCHED_SAT_EN saturates res_data to 16 bits and adds
// the sat_flag output; without it res_data is the wrapped low 16 bits of the product.
module case_7_mul_rr_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned MUL_STAGES = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*10-1:0] req_a,
  input  logic [NUM_REQ*8-1:0]  req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [15:0]           res_data,
  output logic [ID_W-1:0]       res_id,
`ifdef CASE_7_MUL_RR_SCHED_SAT_EN
  output logic                  sat_flag,
`endif
  output logic                  busy
);

  localparam logic [ID_W-1:0] LastId = ID_W'(NUM_REQ - 1);

  // Pipeline state: one valid/product/id slot per stage; the last stage drives the result port.
  logic [MUL_STAGES-1:0]  vld_q;
  logic signed [17:0]     prod_q [MUL_STAGES];
  logic [ID_W-1:0]        id_q   [MUL_STAGES];
  logic [ID_W-1:0]        ptr_q, ptr_d;

  logic                   stall;
  logic                   win_found;
  logic [ID_W-1:0]        win_idx;
  logic                   accept;
  logic signed [9:0]      a_sel;
  logic signed [7:0]      b_sel;
  logic signed [17:0]     prod_new;
  logic [ID_W:0]          cand;

  assign res_valid = vld_q[MUL_STAGES-1];
  assign res_id    = id_q[MUL_STAGES-1];
  assign stall     = res_valid & ~res_ready;
  assign busy      = |vld_q;

  // Rotating priority search: first valid requester at or after ptr_q, modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Grant is withheld while the output is stalled and while reset is held, so nothing is
  // advertised as accepted that the pipeline will not capture.
  always_comb begin
    req_ready = '0;
    if (ap_rst_n && win_found && !stall) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  assign accept = ap_rst_n & win_found & ~stall;

  // Operand mux for the winning requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_idx) begin
        a_sel = req_a[i*10 +: 10];
        b_sel = req_b[i*8 +: 8];
      end
    end
  end

  // Full-precision signed product; 18 bits cannot overflow for 10b x 8b operands.
  assign prod_new = 18'(a_sel) * 18'(b_sel);

  // Pointer advances past the winner only when an operation is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (win_idx == LastId) ? '0 : win_idx + ID_W'(1);
    end
  end

  // Pipeline advance: everything freezes on stall, otherwise shift one stage per cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q <= '0;
      ptr_q <= '0;
      for (int s = 0; s < int'(MUL_STAGES); s++) begin
        prod_q[s] <= '0;
        id_q[s]   <= '0;
      end
    end else if (!stall) begin
      ptr_q    <= ptr_d;
      vld_q[0] <= accept;
      if (accept) begin
        prod_q[0] <= prod_new;
        id_q[0]   <= win_idx;
      end
      for (int s = 1; s < int'(MUL_STAGES); s++) begin
        vld_q[s]  <= vld_q[s-1];
        prod_q[s] <= prod_q[s-1];
        id_q[s]   <= id_q[s-1];
      end
    end
  end

`ifdef CASE_7_MUL_RR_SCHED_SAT_EN
  localparam logic signed [17:0] SatMax = 18'sd32767;
  localparam logic signed [17:0] SatMin = -18'sd32768;

  // Clamp the final-stage product into the 16-bit signed range and flag when clamped.
  always_comb begin
    res_data = prod_q[MUL_STAGES-1][15:0];
    sat_flag = 1'b0;
    if (prod_q[MUL_STAGES-1] > SatMax) begin
      res_data = 16'h7fff;
      sat_flag = 1'b1;
    end else if (prod_q[MUL_STAGES-1] < SatMin) begin
      res_data = 16'h8000;
      sat_flag = 1'b1;
    end
  end
`else
  // Two's-complement wrap of the final-stage product.
  always_comb begin
    res_data = prod_q[MUL_STAGES-1][15:0];
  end
`endif

endmodule

// File: tb/tb_case_7_mul_rr_sched.sv
// Bench for case_7_mul_rr_sched: a 4-requester/1-stage instance checked against a queue-based
// reference model under directed and random traffic, plus a 3-requester/3-stage instance
// exercised with directed round-robin wrap and mid-flight reset sequences.
module tb_case_7_mul_rr_sched;

  localparam int L0 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 4-requester, 1-stage instance
  logic        rst0_n;
  logic [3:0]  v0, rdy0;
  logic [39:0] a0;
  logic [31:0] b0;
  logic        rr0, rv0, busy0;
  logic [15:0] rd0;
  logic [1:0]  rid0;

  // 3-requester, 3-stage instance
  logic        rst3_n;
  logic [2:0]  v3, rdy3;
  logic [29:0] a3;
  logic [23:0] b3;
  logic        rr3, rv3, busy3;
  logic [15:0] rd3;
  logic [1:0]  rid3;

`ifdef CASE_7_MUL_RR_SCHED_SAT_EN
  logic sat0, sat3;
`endif

  case_7_mul_rr_sched #(.NUM_REQ(4), .ID_W(2), .MUL_STAGES(1)) dut0 (
    .ap_clk    (clk),
    .ap_rst_n  (rst0_n),
    .req_valid (v0),
    .req_ready (rdy0),
    .req_a     (a0),
    .req_b     (b0),
    .res_valid (rv0),
    .res_ready (rr0),
    .res_data  (rd0),
    .res_id    (rid0),
`ifdef CASE_7_MUL_RR_SCHED_SAT_EN
    .sat_flag  (sat0),
`endif
    .busy      (busy0)
  );

  case_7_mul_rr_sched #(.NUM_REQ(3), .ID_W(2), .MUL_STAGES(3)) dut3 (
    .ap_clk    (clk),
    .ap_rst_n  (rst3_n),
    .req_valid (v3),
    .req_ready (rdy3),
    .req_a     (a3),
    .req_b     (b3),
    .res_valid (rv3),
    .res_ready (rr3),
    .res_data  (rd3),
    .res_id    (rid3),
`ifdef CASE_7_MUL_RR_SCHED_SAT_EN
    .sat_flag  (sat3),
`endif
    .busy      (busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: ordered queue of in-flight results, each with the number of pipeline
  // advances it has seen; a result is visible once it has advanced L0 times.
  typedef struct {
    int id;
    int data;
    int sat;
    int age;
  } ent_t;

  ent_t q[$];
  int   ptr_m = 0;

  function automatic int ref_data(input int a, input int b);
    int p;
    p = a * b;
`ifdef CASE_7_MUL_RR_SCHED_SAT_EN
    if (p > 32767) return 32'h7fff;
    if (p < -32768) return 32'h8000;
`endif
    return p & 32'hffff;
  endfunction

  function automatic int ref_sat(input int a, input int b);
    int p;
    p = a * b;
    return (p > 32767 || p < -32768) ? 1 : 0;
  endfunction

  // One cycle on dut0: drive on the falling edge, check against the model, advance the model.
  task automatic step0(input logic [3:0] v, input logic [39:0] a, input logic [31:0] b,
                       input logic rr);
    logic       exp_valid, stall;
    int         win, idx, av, bv;
    logic [3:0] exp_rdy;
    ent_t       e;
    @(negedge clk);
    v0 = v; a0 = a; b0 = b; rr0 = rr;
    #1;
    exp_valid = (q.size() > 0) && (q[0].age == L0);
    stall     = exp_valid && !rr;
    win = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (ptr_m + k) % 4;
      if (win < 0 && v[idx]) win = idx;
    end
    exp_rdy = (win >= 0 && !stall) ? 4'(1 << win) : 4'b0;
    chk("req_ready", 32'(rdy0), 32'(exp_rdy));
    chk("res_valid", 32'(rv0), 32'(exp_valid));
    chk("busy", 32'(busy0), 32'(q.size() > 0));
    if (exp_valid) begin
      chk("res_data", 32'(rd0), 32'(q[0].data));
      chk("res_id", 32'(rid0), 32'(q[0].id));
`ifdef CASE_7_MUL_RR_SCHED_SAT_EN
      chk("sat_flag", 32'(sat0), 32'(q[0].sat));
`endif
    end
    if (!stall) begin
      if (exp_valid) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (win >= 0) begin
        av    = int'($signed(a[10*win +: 10]));
        bv    = int'($signed(b[8*win +: 8]));
        e.id   = win;
        e.data = ref_data(av, bv);
        e.sat  = ref_sat(av, bv);
        e.age  = 1;
        q.push_back(e);
        ptr_m = (win + 1) % 4;
      end
    end
  endtask

  task automatic reset0();
    @(negedge clk);
    rst0_n = 1'b0;
    v0     = 4'hf;
    #1;
    chk("rst0_res_valid", 32'(rv0), 32'd0);
    chk("rst0_busy", 32'(busy0), 32'd0);
    chk("rst0_req_ready", 32'(rdy0), 32'd0);
    q.delete();
    ptr_m = 0;
    @(negedge clk);
    rst0_n = 1'b1;
    v0     = 4'h0;
  endtask

  logic [39:0] abus;
  logic [31:0] bbus;

  initial begin
    rst0_n = 1'b0; v0 = 4'hf; a0 = '0; b0 = '0; rr0 = 1'b1;
    rst3_n = 1'b0; v3 = 3'b111; a3 = '0; b3 = '0; rr3 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_res_valid", 32'(rv0), 32'd0);
    chk("reset_res_data", 32'(rd0), 32'd0);
    chk("reset_res_id", 32'(rid0), 32'd0);
    chk("reset_req_ready", 32'(rdy0), 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset3_req_ready", 32'(rdy3), 32'd0);
    chk("reset3_res_valid", 32'(rv3), 32'd0);
    @(negedge clk);
    rst0_n = 1'b1; v0 = 4'h0;
    rst3_n = 1'b1; v3 = 3'b000;

    // Single requester 2: 100 * -3 = -300
    abus = '0; bbus = '0;
    abus[20 +: 10] = 10'd100;
    bbus[16 +: 8]  = 8'hfd;
    step0(4'b0100, abus, bbus, 1'b1);
    step0(4'b0000, abus, bbus, 1'b1);
    chk("single_valid", 32'(rv0), 32'd1);
    chk("single_data", 32'(rd0), 32'h0000fed4);
    chk("single_id", 32'(rid0), 32'd2);

    // All requesters valid: strict rotation starting from 0 after reset
    reset0();
    for (int c = 0; c < 8; c++) begin
      step0(4'hf, 40'({$urandom, $urandom}), $urandom, 1'b1);
      chk("rr_grant", 32'(rdy0), 32'(1 << (c % 4)));
      if (c >= 1) chk("rr_res_id", 32'(rid0), 32'((c - 1) % 4));
    end

    // Back-pressure: no grants while the result is held
    for (int c = 0; c < 3; c++) begin
      step0(4'hf, 40'({$urandom, $urandom}), $urandom, 1'b0);
      chk("bp_req_ready", 32'(rdy0), 32'd0);
      chk("bp_res_valid", 32'(rv0), 32'd1);
    end
    for (int c = 0; c < 4; c++) step0(4'hf, 40'({$urandom, $urandom}), $urandom, 1'b1);
    step0(4'h0, '0, '0, 1'b1);

    // Overflow corners
    reset0();
    abus = '0; bbus = '0;
    abus[0 +: 10] = 10'd511;
    bbus[0 +: 8]  = 8'd127;
    step0(4'b0001, abus, bbus, 1'b1);
    abus[0 +: 10] = 10'h200;
    bbus[0 +: 8]  = 8'h80;
    step0(4'b0001, abus, bbus, 1'b1);
`ifdef CASE_7_MUL_RR_SCHED_SAT_EN
    chk("ovf_pos_data", 32'(rd0), 32'h00007fff);
    chk("ovf_pos_sat", 32'(sat0), 32'd1);
`else
    chk("ovf_pos_data", 32'(rd0), 32'h0000fd81);
`endif
    step0(4'b0000, abus, bbus, 1'b1);
`ifdef CASE_7_MUL_RR_SCHED_SAT_EN
    chk("ovf_neg_data", 32'(rd0), 32'h00007fff);
    chk("ovf_neg_sat", 32'(sat0), 32'd1);
`else
    chk("ovf_neg_data", 32'(rd0), 32'h00000000);
`endif
    step0(4'b0000, abus, bbus, 1'b1);

    // Random traffic against the model
    reset0();
    for (int c = 0; c < 400; c++) begin
      step0(4'($urandom), 40'({$urandom, $urandom}), $urandom, ($urandom % 4) != 0);
    end
    for (int c = 0; c < 4; c++) step0(4'h0, '0, '0, 1'b1);

    // NUM_REQ=3, 3 stages: requesters 0 and 2 alternate, pointer wraps 2 -> 0
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      v3 = 3'b101; rr3 = 1'b1;
      a3 = '0; b3 = '0;
      a3[0 +: 10]  = 10'd5;
      b3[0 +: 8]   = 8'hf9;
      a3[20 +: 10] = 10'h39c;
      b3[16 +: 8]  = 8'd3;
      #1;
      chk("nr3_grant", 32'(rdy3), (c % 2 == 0) ? 32'b001 : 32'b100);
      chk("nr3_res_valid", 32'(rv3), 32'(c >= 3));
      if (c >= 3) begin
        chk("nr3_res_id", 32'(rid3), ((c - 3) % 2 == 0) ? 32'd0 : 32'd2);
        chk("nr3_res_data", 32'(rd3), ((c - 3) % 2 == 0) ? 32'h0000ffdd : 32'h0000fed4);
      end
    end
    @(negedge clk);
    v3 = 3'b000;

    // Reset with operations in flight; pointer sits at 1 before reset
    @(negedge clk);
    rst3_n = 1'b0;
    v3     = 3'b101;
    #1;
    chk("midrst_res_valid", 32'(rv3), 32'd0);
    chk("midrst_busy", 32'(busy3), 32'd0);
    chk("midrst_res_data", 32'(rd3), 32'd0);
    chk("midrst_res_id", 32'(rid3), 32'd0);
    chk("midrst_req_ready", 32'(rdy3), 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    v3     = 3'b000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_stale", 32'(rv3), 32'd0);
      chk("post_rst_busy", 32'(busy3), 32'd0);
    end
    @(negedge clk);
    v3 = 3'b101;
    #1;
    chk("post_rst_first_grant", 32'(rdy3), 32'b001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
